// File: rtl/digital_decimation_mc.sv
// Multi-channel run-time programmable decimator for the logic capture path.
// Folds each window of accepted samples into one result and hands it off through a one-entry output register.
module digital_decimation_mc #(
    parameter int CHANNELS    = 16,
    parameter int RATIO_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [RATIO_WIDTH-1:0] ratio,
    input  logic [1:0]             mode,
    input  logic                   in_valid,
    input  logic [CHANNELS-1:0]    in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CHANNELS-1:0]    out_data,
    output logic [CHANNELS-1:0]    out_aux,
    output logic                   overflow,
    input  logic                   clr_ovf
);

    typedef enum logic [1:0] {
        MODE_SAMPLE = 2'd0,
        MODE_PEAK   = 2'd1,
        MODE_EDGE   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_t;

    localparam logic [RATIO_WIDTH-1:0] ONE = RATIO_WIDTH'(1);

    logic [RATIO_WIDTH-1:0] cnt;
    logic [RATIO_WIDTH-1:0] n_lat;
    mode_t                  mode_lat;
    logic [CHANNELS-1:0]    first_acc;
    logic [CHANNELS-1:0]    or_acc;
    logic [CHANNELS-1:0]    and_acc;
    logic [CHANNELS-1:0]    edge_acc;
    logic [CHANNELS-1:0]    prev;
    logic                   prev_valid;

    logic                   accept;
    logic                   start;
    logic [RATIO_WIDTH-1:0] n_eff;
    mode_t                  mode_eff;
    logic [CHANNELS-1:0]    first_nxt;
    logic [CHANNELS-1:0]    or_nxt;
    logic [CHANNELS-1:0]    and_nxt;
    logic [CHANNELS-1:0]    edge_nxt;
    logic                   close;
    logic [CHANNELS-1:0]    res_data;
    logic [CHANNELS-1:0]    res_aux;
    logic                   load;
    logic                   drop;

    // The first sample of a window uses the live config, which is also what gets latched for the rest of it.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        accept    = en && in_valid;
        start     = (cnt == '0);
        n_eff     = n_lat;
        mode_eff  = mode_lat;
        first_nxt = first_acc;
        or_nxt    = or_acc | in_data;
        and_nxt   = and_acc & in_data;
        edge_nxt  = edge_acc;
        res_data  = '0;
        res_aux   = '0;

        if (start) begin
            n_eff     = (ratio == '0) ? ONE : ratio;
            mode_eff  = mode_t'(mode);
            first_nxt = in_data;
            or_nxt    = in_data;
            and_nxt   = in_data;
            edge_nxt  = '0;
        end
        if (prev_valid) begin
            edge_nxt = edge_nxt | (in_data ^ prev);
        end

        close = accept && (cnt == n_eff - ONE);

        case (mode_eff)
            MODE_PEAK: begin
                res_data = or_nxt;
                res_aux  = and_nxt;
            end
            MODE_EDGE: begin
                res_data = in_data;
                res_aux  = edge_nxt;
            end
            default: begin
                res_data = first_nxt;
                res_aux  = '0;
            end
        endcase

        load = close && (!out_valid || out_ready);
        drop = close && out_valid && !out_ready;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst || !en) begin
            cnt        <= '0;
            n_lat      <= ONE;
            mode_lat   <= MODE_SAMPLE;
            first_acc  <= '0;
            or_acc     <= '0;
            and_acc    <= '0;
            edge_acc   <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (accept) begin
            cnt        <= close ? '0 : cnt + ONE;
            first_acc  <= first_nxt;
            or_acc     <= or_nxt;
            and_acc    <= and_nxt;
            edge_acc   <= edge_nxt;
            prev       <= in_data;
            prev_valid <= 1'b1;
            if (start) begin
                n_lat    <= n_eff;
                mode_lat <= mode_eff;
            end
        end
    end

    // Output register survives en low; only rst empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_aux   <= '0;
            overflow  <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= res_data;
                out_aux   <= res_aux;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_digital_decimation_mc.sv
// Self-checking bench for digital_decimation_mc: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a window-queue model.
module tb_digital_decimation_mc;

    localparam int CH = 16;
    localparam int RW = 16;

    logic          clk;
    logic          rst;
    logic          en;
    logic [RW-1:0] ratio;
    logic [1:0]    mode;
    logic          in_valid;
    logic [CH-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CH-1:0] out_data;
    logic [CH-1:0] out_aux;
    logic          overflow;
    logic          clr_ovf;

    int tests_run = 0;
    int tests_failed = 0;

    digital_decimation_mc #(.CHANNELS(CH), .RATIO_WIDTH(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ratio     (ratio),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_aux   (out_aux),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a window is a list of samples; its result is computed when the list reaches N.
    logic [CH-1:0] win[$];
    logic [CH-1:0] eb[$];
    int            m_n;
    logic [1:0]    m_mode;
    logic [CH-1:0] m_prev;
    bit            m_pv;
    logic          exp_valid;
    logic [CH-1:0] exp_data;
    logic [CH-1:0] exp_aux;
    logic          exp_ovf;
    logic [31:0]   got[$];

    always @(posedge clk) begin
        logic [CH-1:0] rd, ra, o, a, e;
        bit close, drop;
        if (out_valid && out_ready) got.push_back({out_data, out_aux});
        if (rst) begin
            win.delete();
            eb.delete();
            m_pv      = 0;
            exp_valid = 1'b0;
            exp_data  = '0;
            exp_aux   = '0;
            exp_ovf   = 1'b0;
        end else begin
            close = 0;
            drop  = 0;
            rd    = '0;
            ra    = '0;
            if (!en) begin
                win.delete();
                eb.delete();
                m_pv = 0;
            end else if (in_valid) begin
                if (win.size() == 0) begin
                    m_n    = (ratio == 0) ? 1 : int'(ratio);
                    m_mode = mode;
                end
                win.push_back(in_data);
                eb.push_back(m_pv ? (in_data ^ m_prev) : '0);
                m_prev = in_data;
                m_pv   = 1;
                if (win.size() == m_n) begin
                    o = '0;
                    a = '1;
                    e = '0;
                    foreach (win[i]) begin
                        o |= win[i];
                        a &= win[i];
                        e |= eb[i];
                    end
                    case (m_mode)
                        2'd1:    begin rd = o; ra = a; end
                        2'd2:    begin rd = win[win.size()-1]; ra = e; end
                        default: begin rd = win[0]; ra = '0; end
                    endcase
                    close = 1;
                    win.delete();
                    eb.delete();
                end
            end
            if (close && (!exp_valid || out_ready)) begin
                exp_valid = 1'b1;
                exp_data  = rd;
                exp_aux   = ra;
            end else begin
                if (close) drop = 1;
                if (exp_valid && out_ready) exp_valid = 1'b0;
            end
            if (drop) exp_ovf = 1'b1;
            else if (clr_ovf) exp_ovf = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        check("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
            check("out_data", out_data, exp_data);
            check("out_aux", out_aux, exp_aux);
        end
        check("overflow", overflow, exp_ovf);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [CH-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; ratio = 16'd1; mode = 2'd0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clr_ovf = 1'b0;
        tick();
        tick();
        check("reset_valid", out_valid, 1'b0);
        check("reset_data", out_data, 32'h0);
        check("reset_aux", out_aux, 32'h0);
        check("reset_ovf", overflow, 1'b0);
        rst = 1'b0;

        // SAMPLE, ratio 4, ramp 0..11
        got.delete();
        mode = 2'd0; ratio = 16'd4;
        for (int i = 0; i < 12; i++) send(CH'(i));
        idle(2);
        check("s1_count", got.size(), 3);
        if (got.size() == 3) begin
            check("s1_r0", got[0], {16'd0, 16'd0});
            check("s1_r1", got[1], {16'd4, 16'd0});
            check("s1_r2", got[2], {16'd8, 16'd0});
        end

        // PEAK, ratio 8, glitches on ch0 and ch1
        got.delete();
        mode = 2'd1; ratio = 16'd8;
        for (int i = 0; i < 8; i++) send({14'h1A5B, (i != 2) ? 1'b1 : 1'b0, (i == 5) ? 1'b1 : 1'b0});
        idle(2);
        check("s2_count", got.size(), 1);
        if (got.size() == 1) check("s2_r0", got[0], {14'h1A5B, 2'b11, 14'h1A5B, 2'b00});

        // EDGE, ratio 4, ch3 rises between sample 3 and 4
        got.delete();
        en = 1'b0; tick(); en = 1'b1;
        mode = 2'd2; ratio = 16'd4;
        for (int i = 0; i < 8; i++) send((i >= 4) ? 16'h0008 : 16'h0000);
        idle(1);
        en = 1'b0; tick(); en = 1'b1;
        for (int i = 0; i < 4; i++) send(16'h00FF);
        idle(2);
        check("s3_count", got.size(), 3);
        if (got.size() == 3) begin
            check("s3_w0", got[0], {16'h0000, 16'h0000});
            check("s3_w1", got[1], {16'h0008, 16'h0008});
            check("s3_after_en", got[2], {16'h00FF, 16'h0000});
        end

        // Back-pressure at ratio 1
        mode = 2'd0; ratio = 16'd1; out_ready = 1'b0;
        send(16'd1); send(16'd2); send(16'd3);
        check("s4_held_valid", out_valid, 1'b1);
        check("s4_held_data", out_data, 32'd1);
        check("s4_ovf_set", overflow, 1'b1);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        check("s4_ovf_clr", overflow, 1'b0);
        clr_ovf = 1'b1; send(16'd4); clr_ovf = 1'b0;
        check("s4_set_wins", overflow, 1'b1);
        got.delete();
        out_ready = 1'b1;
        idle(2);
        check("s4_count", got.size(), 1);
        if (got.size() == 1) check("s4_r0", got[0], {16'd1, 16'd0});
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;

        // Ratio change mid-window, then ratio 0
        got.delete();
        ratio = 16'd4;
        send(16'd0); send(16'd1);
        ratio = 16'd2;
        for (int i = 2; i < 10; i++) send(CH'(i));
        ratio = 16'd0;
        for (int i = 20; i < 23; i++) send(CH'(i));
        idle(2);
        check("s5_count", got.size(), 7);
        if (got.size() == 7) begin
            check("s5_r0", got[0][31:16], 32'd0);
            check("s5_r1", got[1][31:16], 32'd4);
            check("s5_r2", got[2][31:16], 32'd6);
            check("s5_r3", got[3][31:16], 32'd8);
            check("s5_r4", got[4][31:16], 32'd20);
            check("s5_r6", got[6][31:16], 32'd22);
        end

        // Abort by en and by rst
        got.delete();
        ratio = 16'd4;
        send(16'd30); send(16'd31);
        en = 1'b0; idle(1); en = 1'b1;
        for (int i = 40; i < 44; i++) send(CH'(i));
        idle(2);
        check("s6_en_count", got.size(), 1);
        if (got.size() == 1) check("s6_en_r0", got[0][31:16], 32'd40);

        ratio = 16'd1; out_ready = 1'b0;
        send(16'd77);
        ratio = 16'd4;
        send(16'd1); send(16'd2);
        rst = 1'b1; tick(); rst = 1'b0;
        check("s6_rst_valid", out_valid, 1'b0);
        check("s6_rst_data", out_data, 32'h0);
        check("s6_rst_aux", out_aux, 32'h0);
        check("s6_rst_ovf", overflow, 1'b0);

        got.delete();
        ratio = 16'd1;
        send(16'd55);
        en = 1'b0;
        idle(3);
        check("s6_hold_valid", out_valid, 1'b1);
        check("s6_hold_data", out_data, 32'd55);
        out_ready = 1'b1;
        tick();
        check("s6_drain_valid", out_valid, 1'b0);
        check("s6_drain_count", got.size(), 1);
        en = 1'b1;

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            en        = ($urandom_range(0, 39) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = CH'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            clr_ovf   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) begin
                mode  = 2'($urandom_range(0, 3));
                ratio = ($urandom_range(0, 9) == 0) ? 16'd17 : 16'($urandom_range(0, 5));
            end
            tick();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_ovf = 1'b0;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
